rr_exe_skid: RTL and testbench
==============================

Name: rr_exe_skid

Overview:
- Pipeline boundary between the register-read/forward-check stage and the functional-unit execute stage of one issue lane.
- Captures the issued packet: operands already resolved by bypass muxing, destination physical tag, control word and branch mask.
- Presents the packet to execute with a valid/ready handshake and a 2-entry skid, so a registered ready never drops data.
- Supports a full flush, plus selective kill and mask-clear on branch resolution.

Parameters:
- DATA_W, 32, operand width (matches `SIZE_DATA).
- TAG_W, 7, physical register tag width (matches `SIZE_PHYSICAL_LOG).
- CTRL_W, 16, opaque control word width (opcode, immediate select, FU id).
- BRM_W, 4, branch mask width, one bit per in-flight unresolved branch.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- in_valid_i  in  1  upstream packet valid.
- in_ready_o  out  1  skid can accept; registered.
- in_src1_i  in  DATA_W  forwarded operand 1.
- in_src2_i  in  DATA_W  forwarded operand 2.
- in_dest_i  in  TAG_W  destination physical tag.
- in_ctrl_i  in  CTRL_W  control word.
- in_brmask_i  in  BRM_W  branches this packet depends on.
- out_valid_o  out  1  packet presented to execute.
- out_ready_i  in  1  execute accepts.
- out_src1_o  out  DATA_W  operand 1.
- out_src2_o  out  DATA_W  operand 2.
- out_dest_o  out  TAG_W  destination tag.
- out_ctrl_o  out  CTRL_W  control word.
- out_brmask_o  out  BRM_W  current branch mask.
- flush_i  in  1  kill all entries (exception/replay).
- br_resolve_i  in  1  a branch resolved this cycle.
- br_mispred_i  in  1  qualifies br_resolve_i: the resolved branch mispredicted.
- br_bit_i  in  BRM_W  one-hot bit of the resolved branch.

Behaviour:
- Storage: MAIN entry (drives the out_* ports) and SKID entry. Each holds a valid bit plus the full payload.
- Reset (reset_n low at a clock edge):
  - MAIN.valid = 0, SKID.valid = 0.
  - in_ready_o = 1, out_valid_o = 0.
  - Payload outputs are 0.
  - Reset wins over every other input.
- Occupancy states: EMPTY (neither valid), ONE (MAIN only), FULL (MAIN and SKID). SKID valid while MAIN invalid is illegal; an assertion must flag it.
- Handshake events:
  - accept = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
- in_ready_o is registered. Next value is 1 unless the next state is FULL.
- Latency: a packet accepted into EMPTY appears on out_* the next cycle.
- Transitions (no flush, no kill):
  - EMPTY + accept -> ONE.
  - ONE + accept, no pop -> FULL; new packet goes to SKID.
  - ONE + accept + pop -> ONE; new packet goes to MAIN.
  - ONE + pop, no accept -> EMPTY.
  - FULL + pop -> ONE; SKID moves to MAIN.
  - FULL: accept is impossible because in_ready_o = 0.
- Order is strictly FIFO. No packet is duplicated or dropped.
- Branch resolve:
  - Applies when br_resolve_i = 1, to every valid stored entry and to the entry being written this cycle.
  - If br_mispred_i = 1 and (brmask & br_bit_i) != 0: the entry is invalidated.
  - If br_mispred_i = 0: the entry's brmask is cleared with brmask & ~br_bit_i.
- Kill compaction: if MAIN is killed and SKID survives, SKID moves to MAIN in the same edge. FIFO order is preserved.
- A pop in the same cycle as a kill of MAIN still counts as a consumed handshake. Execute must also see br_mispred_i and squash the packet itself.
- flush_i:
  - Next cycle: both entries invalid, in_ready_o = 1.
  - The incoming packet that cycle is discarded.
  - flush_i has priority over accept and branch resolve.
- Payload registers update only on a write, so there is no toggling when idle. Outputs are held stable while out_valid_o & ~out_ready_i.

Decomposition:
- Shared package holds:
  - rr_exe_pkt_t struct: src1, src2, dest, ctrl, brmask.
  - The width constants tied to the `SIZE_* macros.
  - The brmask kill/clear helper function, which is reused by the issue queue and load-store queue.
- One sub-module: br_mask_update. It is combinational; it takes an entry's valid and brmask and returns next valid and brmask. It is instantiated for MAIN, SKID and the incoming packet.

Test Plan:
- Reset, then one packet with src1=0x11, dest=5; out_ready_i=1 -> out_valid_o=1 with src1=0x11 exactly one cycle after accept; in_ready_o stays 1.
- Hold out_ready_i=0 and send packets A, then B -> FULL; in_ready_o=0 on the cycle after B is accepted. Raise out_ready_i -> A then B emerge in order; in_ready_o returns to 1.
- Stream 100 packets with random in_valid_i and out_ready_i -> the output sequence equals the input sequence, with no loss or duplication.
- FULL with MAIN brmask=4'b0010 and SKID brmask=4'b0100; mispredict with br_bit_i=4'b0010 -> next cycle MAIN holds the former SKID packet and the state is ONE.
- Correct resolve with br_bit_i=4'b0100 while in ONE with brmask=4'b0110 -> out_brmask_o=4'b0010, and the entry stays valid.
- flush_i together with in_valid_i in FULL -> next cycle out_valid_o=0, in_ready_o=1, and the incoming packet is never presented. Repeat with reset_n low mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/rr_exe_skid_pkg.sv
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

// Shared types and helpers for the register-read to execute boundary.
// The brmask helper is shared with the issue queue and the load-store queue.
package rr_exe_skid_pkg;

  localparam int DATA_W = `SIZE_DATA;
  localparam int TAG_W  = `SIZE_PHYSICAL_LOG;
  localparam int CTRL_W = 16;
  localparam int BRM_W  = 4;

  // One issued packet with operands already resolved by the bypass network.
  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [TAG_W-1:0]  dest;
    logic [CTRL_W-1:0] ctrl;
    logic [BRM_W-1:0]  brmask;
  } rr_exe_pkt_t;

  // Skid occupancy, exposed for debug and checkers.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  // Valid bit and branch mask of a single entry after a branch resolution.
  typedef struct packed {
    logic             valid;
    logic [BRM_W-1:0] brmask;
  } brm_state_t;

  // Mispredict kills entries that depend on the branch; a correct
  // resolve only drops the branch from the dependency mask.
  function automatic brm_state_t brmask_update(
    input logic             valid,
    input logic [BRM_W-1:0] brmask,
    input logic             resolve,
    input logic             mispred,
    input logic [BRM_W-1:0] br_bit
  );
    brm_state_t r;
    r.valid  = valid;
    r.brmask = brmask;
    if (resolve) begin
      if (mispred) begin
        if (|(brmask & br_bit)) r.valid = 1'b0;
      end else begin
        r.brmask = brmask & ~br_bit;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/br_mask_update.sv
// Combinational branch-resolution update for one stored or incoming entry.
module br_mask_update
   import rr_exe_skid_pkg::*;
(
   input  logic             valid,
   input  logic [BRM_W-1:0] brmask,
   input  logic             br_resolve,
   input  logic             br_mispred,
   input  logic [BRM_W-1:0] br_bit,
   output logic             valid_next,
   output logic [BRM_W-1:0] brmask_next
);

   brm_state_t upd;

   // Apply the shared kill/clear rule to this entry.
   always_comb begin
      upd         = brmask_update(valid, brmask, br_resolve, br_mispred, br_bit);
      valid_next  = upd.valid;
      brmask_next = upd.brmask;
   end

endmodule

// File: rtl/rr_exe_skid.sv
// Two-entry skid between register-read and execute. MAIN drives the
// outputs, SKID catches the packet accepted while execute stalls, so a
// registered in_ready_o never loses data. Handshake: a transfer happens on
// a rising edge where valid and ready are both high; a presented packet
// stays stable until it is taken, flushed or killed by a mispredict.
module rr_exe_skid
   import rr_exe_skid_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_src1_i,
   input  logic [DATA_W-1:0] in_src2_i,
   input  logic [TAG_W-1:0]  in_dest_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [BRM_W-1:0]  in_brmask_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_src1_o,
   output logic [DATA_W-1:0] out_src2_o,
   output logic [TAG_W-1:0]  out_dest_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [BRM_W-1:0]  out_brmask_o,
   input  logic              flush_i,
   input  logic              br_resolve_i,
   input  logic              br_mispred_i,
   input  logic [BRM_W-1:0]  br_bit_i,
   output occ_t              occ_state
);

   rr_exe_pkt_t main_q, skid_q, main_d, skid_d, inc_pkt;
   logic        main_v, skid_v, ready_q;
   logic        main_nv, skid_nv, main_we, skid_we;
   logic        accept, pop;
   logic        main_uv, skid_uv, inc_uv;
   logic [BRM_W-1:0] main_ubm, skid_ubm, inc_ubm;
   logic        main_keep, skid_keep, inc_keep;

   assign accept = in_valid_i & ready_q;
   assign pop    = main_v & out_ready_i;

   br_mask_update u_upd_main (
      .valid(main_v), .brmask(main_q.brmask), .br_resolve(br_resolve_i),
      .br_mispred(br_mispred_i), .br_bit(br_bit_i),
      .valid_next(main_uv), .brmask_next(main_ubm)
   );

   br_mask_update u_upd_skid (
      .valid(skid_v), .brmask(skid_q.brmask), .br_resolve(br_resolve_i),
      .br_mispred(br_mispred_i), .br_bit(br_bit_i),
      .valid_next(skid_uv), .brmask_next(skid_ubm)
   );

   br_mask_update u_upd_inc (
      .valid(accept), .brmask(in_brmask_i), .br_resolve(br_resolve_i),
      .br_mispred(br_mispred_i), .br_bit(br_bit_i),
      .valid_next(inc_uv), .brmask_next(inc_ubm)
   );

   // A popped MAIN leaves just like a killed one; the survivors compact
   // into MAIN then SKID in arrival order.
   assign main_keep = main_uv & ~pop;
   assign skid_keep = skid_uv;
   assign inc_keep  = inc_uv;

   // Pick the next MAIN/SKID contents and which payload registers to write.
   always_comb begin
      main_nv = 1'b0;
      skid_nv = 1'b0;
      main_we = 1'b0;
      skid_we = 1'b0;
      inc_pkt = '{src1: in_src1_i, src2: in_src2_i, dest: in_dest_i,
                  ctrl: in_ctrl_i, brmask: inc_ubm};
      main_d        = main_q;
      main_d.brmask = main_ubm;
      skid_d        = skid_q;
      skid_d.brmask = skid_ubm;
      if (main_keep) begin
         main_nv = 1'b1;
         main_we = br_resolve_i;
         if (skid_keep) begin
            skid_nv = 1'b1;
            skid_we = br_resolve_i;
         end else if (inc_keep) begin
            skid_nv = 1'b1;
            skid_we = 1'b1;
            skid_d  = inc_pkt;
         end
      end else if (skid_keep) begin
         main_nv = 1'b1;
         main_we = 1'b1;
         main_d  = skid_d;
         if (inc_keep) begin
            skid_nv = 1'b1;
            skid_we = 1'b1;
            skid_d  = inc_pkt;
         end
      end else if (inc_keep) begin
         main_nv = 1'b1;
         main_we = 1'b1;
         main_d  = inc_pkt;
      end
   end

   // Entry state, registered ready, and write-enabled payload registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         main_v  <= 1'b0;
         skid_v  <= 1'b0;
         ready_q <= 1'b1;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (flush_i) begin
         main_v  <= 1'b0;
         skid_v  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         main_v  <= main_nv;
         skid_v  <= skid_nv;
         ready_q <= ~(main_nv & skid_nv);
         if (main_we) main_q <= main_d;
         if (skid_we) skid_q <= skid_d;
      end
   end

   assign in_ready_o   = ready_q;
   assign out_valid_o  = main_v;
   assign out_src1_o   = main_q.src1;
   assign out_src2_o   = main_q.src2;
   assign out_dest_o   = main_q.dest;
   assign out_ctrl_o   = main_q.ctrl;
   assign out_brmask_o = main_q.brmask;
   assign occ_state    = main_v ? (skid_v ? OCC_FULL : OCC_ONE) : OCC_EMPTY;

   // SKID may only hold a packet behind a valid MAIN.
   a_skid_needs_main: assert property (@(posedge clk) disable iff (!reset_n)
      !(skid_v && !main_v));

endmodule

// File: tb/tb_rr_exe_skid.sv
// Bench for rr_exe_skid: scenario tasks with inline checks and a queue
// scoreboard for in-order delivery.
module tb_rr_exe_skid;
   import rr_exe_skid_pkg::*;

   localparam int PW = DATA_W * 2 + TAG_W + CTRL_W + BRM_W;

   logic              clk;
   logic              reset_n;
   logic              in_valid, in_ready;
   logic [DATA_W-1:0] in_src1, in_src2;
   logic [TAG_W-1:0]  in_dest;
   logic [CTRL_W-1:0] in_ctrl;
   logic [BRM_W-1:0]  in_brmask;
   logic              out_valid, out_ready;
   logic [DATA_W-1:0] out_src1, out_src2;
   logic [TAG_W-1:0]  out_dest;
   logic [CTRL_W-1:0] out_ctrl;
   logic [BRM_W-1:0]  out_brmask;
   logic              flush, br_resolve, br_mispred;
   logic [BRM_W-1:0]  br_bit;
   occ_t              occ;

   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] exp_pkt, got_pkt;
   int            checks, errors;
   bit            sb_en, last_acc;

   rr_exe_skid dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_src1_i(in_src1), .in_src2_i(in_src2), .in_dest_i(in_dest),
      .in_ctrl_i(in_ctrl), .in_brmask_i(in_brmask),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_src1_o(out_src1), .out_src2_o(out_src2), .out_dest_o(out_dest),
      .out_ctrl_o(out_ctrl), .out_brmask_o(out_brmask),
      .flush_i(flush), .br_resolve_i(br_resolve), .br_mispred_i(br_mispred),
      .br_bit_i(br_bit), .occ_state(occ)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one upstream packet; the other fields are derived from src1.
   task automatic set_in(input logic v, input logic [DATA_W-1:0] s1,
                         input logic [TAG_W-1:0] d, input logic [BRM_W-1:0] bm);
      in_valid  = v;
      in_src1   = s1;
      in_src2   = ~s1;
      in_dest   = d;
      in_ctrl   = s1[CTRL_W-1:0] ^ 16'h5a5a;
      in_brmask = bm;
   endtask

   // One cycle: sample handshakes at the falling edge, run the scoreboard,
   // then return 1 time unit after the next rising edge.
   task automatic step();
      @(negedge clk);
      last_acc = in_valid && in_ready && !flush && reset_n;
      if (sb_en) begin
         if (out_valid && out_ready) begin
            got_pkt = {out_src1, out_src2, out_dest, out_ctrl, out_brmask};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra got=%h expected=none", got_pkt);
            end else begin
               exp_pkt = exp_q.pop_front();
               if (got_pkt !== exp_pkt) begin
                  errors++;
                  $display("FAIL sb_order got=%h expected=%h", got_pkt, exp_pkt);
               end
            end
         end
         if (last_acc)
            exp_q.push_back({in_src1, in_src2, in_dest, in_ctrl, in_brmask});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      set_in(1'b0, '0, '0, '0);
      out_ready  = 1'b0;
      flush      = 1'b0;
      br_resolve = 1'b0;
      br_mispred = 1'b0;
      br_bit     = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b expected=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
      checks++; if ({out_src1, out_src2, out_dest, out_ctrl, out_brmask} !== '0) begin
         errors++; $display("FAIL rst_payload got=%h expected=0", {out_src1, out_src2, out_dest, out_ctrl, out_brmask}); end
      checks++; if (occ !== OCC_EMPTY) begin errors++; $display("FAIL rst_occ got=%0d expected=%0d", occ, OCC_EMPTY); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      sb_en = 1'b1;
      out_ready = 1'b1;
      set_in(1'b1, 32'h11, 7'd5, '0);
      step();
      set_in(1'b0, '0, '0, '0);
      checks++; if (out_valid !== 1'b1 || out_src1 !== 32'h11 || out_dest !== 7'd5) begin
         errors++; $display("FAIL single_latency got v=%b src1=%h dest=%0d expected v=1 src1=11 dest=5", out_valid, out_src1, out_dest); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b expected=1", in_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b expected=0", out_valid); end
      sb_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      sb_en = 1'b1;
      out_ready = 1'b0;
      set_in(1'b1, 32'hA0A0, 7'd10, '0);
      step();
      set_in(1'b1, 32'hB0B0, 7'd11, '0);
      step();
      set_in(1'b0, '0, '0, '0);
      checks++; if (in_ready !== 1'b0 || occ !== OCC_FULL) begin
         errors++; $display("FAIL b2b_full got ready=%b occ=%0d expected ready=0 occ=%0d", in_ready, occ, OCC_FULL); end
      step();
      step();
      checks++; if (out_valid !== 1'b1 || out_src1 !== 32'hA0A0) begin
         errors++; $display("FAIL b2b_hold got v=%b src1=%h expected v=1 src1=a0a0", out_valid, out_src1); end
      out_ready = 1'b1;
      step();
      checks++; if (out_src1 !== 32'hB0B0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_second got src1=%h ready=%b expected src1=b0b0 ready=1", out_src1, in_ready); end
      step();
      checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++; $display("FAIL b2b_empty got v=%b left=%0d expected v=0 left=0", out_valid, exp_q.size()); end
      out_ready = 1'b0;
      sb_en = 1'b0;
   endtask

   task automatic test_stream();
      int sent;
      sent  = 0;
      sb_en = 1'b1;
      for (int cyc = 0; cyc < 3000 && !(sent == 100 && exp_q.size() == 0); cyc++) begin
         if (sent < 100)
            set_in(1'($urandom_range(0, 1)), $urandom, 7'($urandom_range(0, 127)), '0);
         else
            set_in(1'b0, '0, '0, '0);
         out_ready = 1'($urandom_range(0, 1));
         step();
         if (last_acc) sent++;
      end
      checks++; if (sent != 100 || exp_q.size() != 0) begin
         errors++; $display("FAIL stream_done got sent=%0d left=%0d expected sent=100 left=0", sent, exp_q.size()); end
      set_in(1'b0, '0, '0, '0);
      out_ready = 1'b0;
      sb_en = 1'b0;
   endtask

   task automatic test_br_kill();
      exp_q.delete();
      out_ready = 1'b0;
      set_in(1'b1, 32'h1A, 7'd1, 4'b0010);
      step();
      set_in(1'b1, 32'h2B, 7'd2, 4'b0100);
      step();
      set_in(1'b0, '0, '0, '0);
      br_resolve = 1'b1; br_mispred = 1'b1; br_bit = 4'b0010;
      step();
      br_resolve = 1'b0; br_mispred = 1'b0; br_bit = '0;
      checks++; if (out_valid !== 1'b1 || out_src1 !== 32'h2B || out_brmask !== 4'b0100) begin
         errors++; $display("FAIL kill_compact got v=%b src1=%h bm=%b expected v=1 src1=2b bm=0100", out_valid, out_src1, out_brmask); end
      checks++; if (occ !== OCC_ONE || in_ready !== 1'b1) begin
         errors++; $display("FAIL kill_occ got occ=%0d ready=%b expected occ=%0d ready=1", occ, in_ready, OCC_ONE); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kill_drain got=%b expected=0", out_valid); end
   endtask

   task automatic test_br_clear();
      set_in(1'b1, 32'h3C, 7'd3, 4'b0110);
      step();
      set_in(1'b0, '0, '0, '0);
      br_resolve = 1'b1; br_mispred = 1'b0; br_bit = 4'b0100;
      step();
      checks++; if (out_valid !== 1'b1 || out_brmask !== 4'b0010 || out_src1 !== 32'h3C) begin
         errors++; $display("FAIL clear_mask got v=%b bm=%b src1=%h expected v=1 bm=0010 src1=3c", out_valid, out_brmask, out_src1); end
      // incoming packet killed by a mispredict in the cycle it is accepted
      set_in(1'b1, 32'h4D, 7'd4, 4'b1000);
      br_resolve = 1'b1; br_mispred = 1'b1; br_bit = 4'b1000;
      step();
      set_in(1'b0, '0, '0, '0);
      br_resolve = 1'b0; br_mispred = 1'b0; br_bit = '0;
      checks++; if (occ !== OCC_ONE || out_src1 !== 32'h3C || in_ready !== 1'b1) begin
         errors++; $display("FAIL kill_incoming got occ=%0d src1=%h ready=%b expected occ=%0d src1=3c ready=1", occ, out_src1, in_ready, OCC_ONE); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_drain got=%b expected=0", out_valid); end
   endtask

   task automatic test_flush_reset();
      set_in(1'b1, 32'h51, 7'd6, '0);
      step();
      set_in(1'b1, 32'h52, 7'd7, '0);
      step();
      set_in(1'b1, 32'hEE, 7'd8, '0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_full got v=%b ready=%b expected v=0 ready=1", out_valid, in_ready); end
      // flush in ONE while a packet is genuinely accepted
      set_in(1'b1, 32'h61, 7'd9, '0);
      step();
      set_in(1'b1, 32'hEF, 7'd12, '0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      set_in(1'b0, '0, '0, '0);
      step();
      checks++; if (out_valid !== 1'b0 || occ !== OCC_EMPTY) begin
         errors++; $display("FAIL flush_discard got v=%b occ=%0d expected v=0 occ=%0d", out_valid, occ, OCC_EMPTY); end
      // reset mid-stream from FULL
      set_in(1'b1, 32'h71, 7'd13, 4'b0001);
      step();
      set_in(1'b1, 32'h72, 7'd14, 4'b0001);
      step();
      reset_n = 1'b0;
      set_in(1'b1, 32'h73, 7'd15, 4'b0001);
      step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occ !== OCC_EMPTY) begin
         errors++; $display("FAIL mid_reset_ctl got v=%b ready=%b occ=%0d expected v=0 ready=1 occ=0", out_valid, in_ready, occ); end
      checks++; if ({out_src1, out_src2, out_dest, out_ctrl, out_brmask} !== '0) begin
         errors++; $display("FAIL mid_reset_payload got=%h expected=0", {out_src1, out_src2, out_dest, out_ctrl, out_brmask}); end
      reset_n = 1'b1;
      set_in(1'b0, '0, '0, '0);
      step();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      sb_en   = 1'b0;
      reset_n = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_back_to_back();
      test_stream();
      test_br_kill();
      test_br_clear();
      test_flush_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
